// File: rtl/mux2to1_var_pkg.sv
// Shared width constants for the 2:1 mux family.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mux2to1_var_pkg;
    localparam int DEFAULT_WIDTH  = 32;
    localparam int DATAPATH_WIDTH = 64;
endpackage

// File: rtl/mux2to1_bit.sv
// One-bit 2:1 selection slice, sum-of-products form.
// Latency: combinational, zero cycles.
// Backpressure: none; no handshake.
module mux2to1_bit
    import mux2to1_var_pkg::*;
(
    input  logic i0,
    input  logic i1,
    input  logic sel,
    output logic out
);

    assign out = (i1 & sel) | (i0 & ~sel);

endmodule

// File: rtl/mux2to1_var.sv
// WIDTH-bit 2:1 mux with combinational result and a registered copy.
// Latency: out is zero-cycle; q follows out one clk edge later.
// Backpressure: none; no handshake, q updates every edge.
module mux2to1_var
    import mux2to1_var_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic             sel,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] q
);

    // One shared select fans out to every bit slice.
    for (genvar k = 0; k < WIDTH; k++) begin : g_bit
        mux2to1_bit u_bit (
            .i0  (i0[k]),
            .i1  (i1[k]),
            .sel (sel),
            .out (out[k])
        );
    end

    // Reset wins over data; a parent tying i0 to q gets a load-enable register.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= out;
        end
    end

endmodule

// File: tb/tb_mux2to1_var.sv
// Scoreboard bench: a free 64-bit instance, a 64-bit hold-loop instance and a 1-bit instance.
module tb_mux2to1_var;
    import mux2to1_var_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // unit 0: free-running 64-bit
    logic        rst_a, sel_a;
    logic [63:0] i0_a, i1_a, out_a, q_a;
    // unit 1: 64-bit with i0 tied to q
    logic        rst_h, sel_h;
    logic [63:0] i1_h, out_h, q_h;
    // unit 2: 1-bit
    logic        rst_b, sel_b, i0_b, i1_b, out_b, q_b;

    mux2to1_var #(.WIDTH(DATAPATH_WIDTH)) u_dut_a (
        .clk(clk), .reset(rst_a), .i0(i0_a), .i1(i1_a), .sel(sel_a), .out(out_a), .q(q_a)
    );
    mux2to1_var #(.WIDTH(DATAPATH_WIDTH)) u_dut_h (
        .clk(clk), .reset(rst_h), .i0(q_h), .i1(i1_h), .sel(sel_h), .out(out_h), .q(q_h)
    );
    mux2to1_var #(.WIDTH(1)) u_dut_b (
        .clk(clk), .reset(rst_b), .i0(i0_b), .i1(i1_b), .sel(sel_b), .out(out_b), .q(q_b)
    );

    typedef struct {
        int          unit;
        string       tag;
        logic [63:0] e_out;
        logic [63:0] e_q;
        bit          chk_q;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Drive one unit for one cycle and queue what it must show this cycle.
    task automatic step(input int unit, input logic r, input logic s,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] e_out, input logic [63:0] e_q,
                        input bit chk_q, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        case (unit)
            0: begin rst_a = r; sel_a = s; i0_a = a; i1_a = b; end
            1: begin rst_h = r; sel_h = s; i1_h = b; end
            default: begin rst_b = r; sel_b = s; i0_b = a[0]; i1_b = b[0]; end
        endcase
        e.unit = unit; e.tag = tag; e.e_out = e_out; e.e_q = e_q; e.chk_q = chk_q;
        sb.push_back(e);
    endtask

    // Monitor: pops every queued expectation on the falling edge.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t        e;
            logic [63:0] a_out, a_q;
            e = sb.pop_front();
            case (e.unit)
                0:       begin a_out = out_a; a_q = q_a; end
                1:       begin a_out = out_h; a_q = q_h; end
                default: begin a_out = {63'd0, out_b}; a_q = {63'd0, q_b}; end
            endcase
            n_cmp++;
            if (a_out !== e.e_out) begin
                n_bad++;
                $display("FAIL %s out: got %h want %h", e.tag, a_out, e.e_out);
            end
            if (e.chk_q) begin
                n_cmp++;
                if (a_q !== e.e_q) begin
                    n_bad++;
                    $display("FAIL %s q: got %h want %h", e.tag, a_q, e.e_q);
                end
            end
        end
    end

    localparam logic [63:0] PA = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] P5 = 64'h5555_5555_5555_5555;

    // 1-bit truth table indexed by {sel, i1, i0}
    logic tt [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_a = 1'b1; sel_a = 1'b0; i0_a = '0; i1_a = '0;
        rst_h = 1'b1; sel_h = 1'b0; i1_h = '0;
        rst_b = 1'b1; sel_b = 1'b0; i0_b = 1'b0; i1_b = 1'b0;

        // Free 64-bit: reset state, then i1=25 selected for 5 cycles
        step(0, 1'b1, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b1, "a_reset");
        step(0, 1'b0, 1'b1, 64'd0, 64'd25, 64'd25, 64'd0, 1'b1, "a_ld25_c1");
        for (int c = 2; c <= 5; c++)
            step(0, 1'b0, 1'b1, 64'd0, 64'd25, 64'd25, 64'd25, 1'b1, $sformatf("a_ld25_c%0d", c));

        // Bit independence: sel toggles 1,0,1,0,1,0
        step(0, 1'b0, 1'b1, PA, P5, P5, 64'd25, 1'b1, "a_alt1");
        step(0, 1'b0, 1'b0, PA, P5, PA, P5, 1'b1, "a_alt2");
        step(0, 1'b0, 1'b1, PA, P5, P5, PA, 1'b1, "a_alt3");
        step(0, 1'b0, 1'b0, PA, P5, PA, P5, 1'b1, "a_alt4");
        step(0, 1'b0, 1'b1, PA, P5, P5, PA, 1'b1, "a_alt5");
        step(0, 1'b0, 1'b0, PA, P5, PA, P5, 1'b1, "a_alt6");
        step(0, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, PA, 1'b1, "a_tail");

        // Hold loop: load 17, hold 5 cycles, load 16, reset, resume
        step(1, 1'b1, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b1, "h_reset");
        step(1, 1'b0, 1'b1, 64'd0, 64'd17, 64'd17, 64'd0, 1'b1, "h_ld17");
        for (int c = 1; c <= 5; c++)
            step(1, 1'b0, 1'b0, 64'd0, 64'd5, 64'd17, 64'd17, 1'b1, $sformatf("h_hold%0d", c));
        step(1, 1'b0, 1'b1, 64'd0, 64'd16, 64'd16, 64'd17, 1'b1, "h_ld16");
        step(1, 1'b1, 1'b1, 64'd0, 64'd17, 64'd17, 64'd16, 1'b1, "h_rst_on");
        step(1, 1'b0, 1'b1, 64'd0, 64'd5, 64'd5, 64'd0, 1'b1, "h_rst_off");
        step(1, 1'b0, 1'b0, 64'd0, 64'd0, 64'd5, 64'd5, 1'b1, "h_resume");

        // 1-bit exhaustive sweep; q lags out by one edge
        step(2, 1'b1, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b1, "b_reset");
        for (int c = 0; c < 8; c++) begin
            logic [2:0]  idx;
            logic [63:0] prev;
            idx  = 3'(c);
            prev = (c == 0) ? 64'd0 : {63'd0, tt[c-1]};
            step(2, 1'b0, idx[2], {63'd0, idx[0]}, {63'd0, idx[1]},
                 {63'd0, tt[c]}, prev, 1'b1, $sformatf("b_tt%0d", c));
        end
        step(2, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, {63'd0, tt[7]}, 1'b1, "b_tail");

        // Drain the scoreboard with a bounded wait
        for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
        @(posedge clk);
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
